// File: rtl/iob_ram_2p_tiled_clr.sv
// Two-port (one write, one read) tiled RAM with byte strobes, an optional
// output register and a clear engine that sweeps every word to zero.
module iob_ram_2p_tiled_clr #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 12,
    parameter int TILE_ADDR_W  = 10,
    parameter int OUT_REG      = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    output logic                busy_o,
    input  logic                w_en_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic                r_en_i,
    input  logic [ADDR_W-1:0]   r_addr_i,
    output logic [DATA_W-1:0]   r_data_o,
    output logic                r_valid_o
);

    localparam int STRB_W     = DATA_W / 8;
    localparam int N_TILES    = 1 << (ADDR_W - TILE_ADDR_W);
    localparam int TILE_IDX_W = (ADDR_W > TILE_ADDR_W) ? (ADDR_W - TILE_ADDR_W) : 1;
    localparam int N_SLOTS    = 1 << TILE_IDX_W;
    localparam int TILE_DEPTH = 1 << TILE_ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_busy;

    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [STRB_W-1:0]   w_wr_strb;
    logic                w_rd_en;
    logic [TILE_IDX_W-1:0] w_wr_tile;
    logic [TILE_IDX_W-1:0] w_rd_tile;

    logic                r_rd_v1;
    logic [TILE_IDX_W-1:0] r_rd_tile1;
    logic [DATA_W-1:0]   w_tile_q [N_SLOTS];
    logic [DATA_W-1:0]   w_rd_mux;

    // Next-state logic: clear requests are only seen in IDLE; the sweep ends after the last word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (clear_i) w_state_next = ST_CLEAR;
            ST_CLEAR: if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register, registered busy flag and sweep counter (wraps to 0 on exit).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_busy    <= (CLEAR_ON_RST != 0);
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_CLEAR);
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    assign busy_o = r_busy;

    // Write-port mux: the sweep owns the port while clearing, user traffic otherwise.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = w_addr_i;
        w_wr_data = w_data_i;
        w_wr_strb = w_strb_i;
        if (!rst_i) begin
            if (r_state == ST_CLEAR) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_cnt;
                w_wr_data = '0;
                w_wr_strb = '1;
            end else begin
                w_wr_en = w_en_i;
            end
        end
    end

    assign w_rd_en   = !rst_i && (r_state == ST_IDLE) && r_en_i;
    assign w_wr_tile = TILE_IDX_W'(w_wr_addr >> TILE_ADDR_W);
    assign w_rd_tile = TILE_IDX_W'(r_addr_i >> TILE_ADDR_W);

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_tile
            if (gi < N_TILES) begin : g_used
                logic [DATA_W-1:0] r_mem [TILE_DEPTH];
                logic [DATA_W-1:0] r_q;
                logic              w_sel_wr;
                logic              w_sel_rd;

                assign w_sel_wr = w_wr_en && (w_wr_tile == TILE_IDX_W'(gi));
                assign w_sel_rd = w_rd_en && (w_rd_tile == TILE_IDX_W'(gi));

                // Byte-strobed write into this tile only.
                always_ff @(posedge clk_i) begin
                    if (w_sel_wr) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_wr_strb[b]) begin
                                r_mem[w_wr_addr[TILE_ADDR_W-1:0]][8*b +: 8] <= w_wr_data[8*b +: 8];
                            end
                        end
                    end
                end

                // Registered read; holds its value when not selected, read-first vs. the write.
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_q <= '0;
                    end else if (w_sel_rd) begin
                        r_q <= r_mem[r_addr_i[TILE_ADDR_W-1:0]];
                    end
                end

                assign w_tile_q[gi] = r_q;
            end else begin : g_unused
                assign w_tile_q[gi] = '0;
            end
        end
    endgenerate

    // Track which tile the pending read came from, and whether a read was launched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_v1    <= 1'b0;
            r_rd_tile1 <= '0;
        end else begin
            r_rd_v1 <= w_rd_en;
            if (w_rd_en) begin
                r_rd_tile1 <= w_rd_tile;
            end
        end
    end

    assign w_rd_mux = w_tile_q[r_rd_tile1];

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_out_data;
            logic              r_out_v;

            // Output register stage: captures the muxed tile data only for real reads.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out_data <= '0;
                    r_out_v    <= 1'b0;
                end else begin
                    r_out_v <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_out_data <= w_rd_mux;
                    end
                end
            end

            assign r_data_o  = r_out_data;
            assign r_valid_o = r_out_v;
        end else begin : g_out_direct
            assign r_data_o  = w_rd_mux;
            assign r_valid_o = r_rd_v1;
        end
    endgenerate

endmodule

// File: tb/tb_iob_ram_2p_tiled_clr.sv
// Directed bench: two instances share all stimulus, one with the output
// register (latency 2) and one without (latency 1).
module tb_iob_ram_2p_tiled_clr;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        w_en_i = 1'b0;
    logic [3:0]  w_strb_i = 4'h0;
    logic [11:0] w_addr_i = '0;
    logic [31:0] w_data_i = '0;
    logic        r_en_i = 1'b0;
    logic [11:0] r_addr_i = '0;

    logic        busy0, busy1;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    always #5 clk = ~clk;

    iob_ram_2p_tiled_clr #(.OUT_REG(1)) dut_reg (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .busy_o(busy0),
        .w_en_i(w_en_i), .w_strb_i(w_strb_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .r_en_i(r_en_i), .r_addr_i(r_addr_i), .r_data_o(rdata0), .r_valid_o(rvalid0)
    );

    iob_ram_2p_tiled_clr #(.OUT_REG(0)) dut_dir (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .busy_o(busy1),
        .w_en_i(w_en_i), .w_strb_i(w_strb_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .r_en_i(r_en_i), .r_addr_i(r_addr_i), .r_data_o(rdata1), .r_valid_o(rvalid1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        w_en_i = 1'b1; w_addr_i = a; w_data_i = d; w_strb_i = s;
        tick();
        w_en_i = 1'b0; w_strb_i = 4'h0;
        $display("write addr=%0d data=%h strb=%h", a, d, s);
    endtask

    task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        r_en_i = 1'b1; r_addr_i = a;
        tick();
        r_en_i = 1'b0;
        check({tag, "_dir_valid"}, {31'd0, rvalid1}, 32'd1);
        check({tag, "_dir_data"}, rdata1, exp);
        tick();
        check({tag, "_reg_valid"}, {31'd0, rvalid0}, 32'd1);
        check({tag, "_reg_data"}, rdata0, exp);
        check({tag, "_dir_valid_drop"}, {31'd0, rvalid1}, 32'd0);
        $display("read  addr=%0d reg=%h dir=%h exp=%h", a, rdata0, rdata1, exp);
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy0 && cnt < 5000) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        // Reset and automatic sweep
        rst_i = 1'b1;
        tick();
        check("rst_valid_reg", {31'd0, rvalid0}, 32'd0);
        check("rst_data_reg", rdata0, 32'd0);
        check("rst_valid_dir", {31'd0, rvalid1}, 32'd0);
        check("rst_data_dir", rdata1, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd1);
        tick();
        rst_i = 1'b0;
        count_busy(n);
        check("rst_sweep_len", n, 32'd4096);
        check("rst_busy_dir_done", {31'd0, busy1}, 32'd0);
        $display("sweep after reset: %0d busy cycles", n);

        read_check("clr0", 12'd0, 32'd0);
        read_check("clr1023", 12'd1023, 32'd0);
        read_check("clr1024", 12'd1024, 32'd0);
        read_check("clr4095", 12'd4095, 32'd0);

        // Fill whole array, then stream reads back-to-back across tiles
        for (int i = 0; i < 4096; i++) begin
            w_en_i = 1'b1; w_addr_i = 12'(i); w_data_i = 32'(i + 32); w_strb_i = 4'hF;
            tick();
        end
        w_en_i = 1'b0; w_strb_i = 4'h0;
        $display("filled 4096 words with i+32");

        for (int k = 0; k < 4096; k++) begin
            r_en_i = 1'b1; r_addr_i = 12'(k);
            tick();
            check("stream_dir_valid", {31'd0, rvalid1}, 32'd1);
            check("stream_dir_data", rdata1, 32'(k + 32));
            if (k >= 1) begin
                check("stream_reg_valid", {31'd0, rvalid0}, 32'd1);
                check("stream_reg_data", rdata0, 32'(k + 31));
            end
        end
        r_en_i = 1'b0;
        tick();
        check("stream_reg_last", rdata0, 32'(4095 + 32));
        check("stream_reg_last_valid", {31'd0, rvalid0}, 32'd1);
        check("stream_dir_idle", {31'd0, rvalid1}, 32'd0);
        $display("streamed 4096 reads");

        // Byte strobes
        write_word(12'd5, 32'hAABBCCDD, 4'hF);
        write_word(12'd5, 32'h11223344, 4'b0010);
        read_check("strb", 12'd5, 32'hAABB33DD);
        write_word(12'd6, 32'h12345678, 4'h0);
        read_check("strb_none", 12'd6, 32'd38);

        // Read-first on same address
        write_word(12'd7, 32'h20, 4'hF);
        r_en_i = 1'b1; r_addr_i = 12'd7;
        w_en_i = 1'b1; w_addr_i = 12'd7; w_data_i = 32'h99; w_strb_i = 4'hF;
        tick();
        r_en_i = 1'b0; w_en_i = 1'b0; w_strb_i = 4'h0;
        check("rfirst_dir", rdata1, 32'h20);
        tick();
        check("rfirst_reg", rdata0, 32'h20);
        $display("read-first addr=7 reg=%h dir=%h", rdata0, rdata1);
        read_check("rfirst_next", 12'd7, 32'h99);

        // Idle read slots hold data and drop valid
        read_check("hold_rd", 12'd3, 32'h23);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_valid_reg", {31'd0, rvalid0}, 32'd0);
            check("hold_data_reg", rdata0, 32'h23);
            check("hold_valid_dir", {31'd0, rvalid1}, 32'd0);
            check("hold_data_dir", rdata1, 32'h23);
        end
        $display("hold 5 idle cycles data=%h", rdata0);

        // Clear request with an ignored second pulse and write during the sweep
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_busy_start", {31'd0, busy0}, 32'd1);
        n = 0;
        while (busy0 && n < 5000) begin
            if (n == 100) begin
                clear_i = 1'b1; w_en_i = 1'b1; w_addr_i = 12'd9;
                w_data_i = 32'h55; w_strb_i = 4'hF;
                r_en_i = 1'b1; r_addr_i = 12'd9;
            end
            tick();
            if (n == 100) begin
                check("clr_no_read_dir", {31'd0, rvalid1}, 32'd0);
            end
            clear_i = 1'b0; w_en_i = 1'b0; w_strb_i = 4'h0; r_en_i = 1'b0;
            n++;
        end
        check("clr_sweep_len", n, 32'd4096);
        $display("clear request: %0d busy cycles", n);
        read_check("clr_addr9", 12'd9, 32'd0);
        read_check("clr_addr3000", 12'd3000, 32'd0);

        // Reset mid-sweep restarts a full sweep
        write_word(12'd100, 32'hDEADBEEF, 4'hF);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        repeat (200) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_busy", {31'd0, busy0}, 32'd1);
        count_busy(n);
        check("mid_rst_sweep_len", n, 32'd4096);
        $display("sweep after mid-sweep reset: %0d busy cycles", n);
        read_check("mid_rst_addr100", 12'd100, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_ram_2p_tiled_clr.md
Name: iob_ram_2p_tiled_clr

Overview:
Parametrised successor to the tiled single-address RAM. Separate read and write addresses, per-byte write strobes and an optional output register stage. A built-in clear engine sweeps the whole array to zero after reset or on request. The array is built from 2^(ADDR_W-TILE_ADDR_W) tiles of 2^TILE_ADDR_W words. It is used as a scratch or frame buffer wherever a known-zero start state is required.

Parameters:
DATA_W, 32, word width; must be a multiple of 8.
ADDR_W, 12, total word-address width (depth 2^ADDR_W).
TILE_ADDR_W, 10, per-tile address width; TILE_ADDR_W <= ADDR_W.
OUT_REG, 1, 1 adds an output register (read latency 2); 0 gives read latency 1.
CLEAR_ON_RST, 1, 1 starts a clear sweep automatically when reset is released.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  reset, synchronous, active-high.
clear_i  in  1  start a clear sweep; sampled only when idle.
busy_o  out  1  clear sweep in progress.
w_en_i  in  1  write enable.
w_strb_i  in  DATA_W/8  byte write strobes.
w_addr_i  in  ADDR_W  write word address.
w_data_i  in  DATA_W  write data.
r_en_i  in  1  read enable.
r_addr_i  in  ADDR_W  read word address.
r_data_o  out  DATA_W  read data.
r_valid_o  out  1  r_data_o updated this cycle with a new read result.

Behaviour:
- Reset (rst_i=1 at an edge):
  - r_data_o=0, r_valid_o=0, pipeline valid bits cleared.
  - Clear counter set to 0.
  - FSM goes to CLEAR if CLEAR_ON_RST=1, else IDLE.
  - busy_o is registered and equals (state==CLEAR) from the first cycle after reset.
  - Array contents are not touched by reset itself.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_i=1; busy_o=1 the next cycle.
  - In CLEAR, one word per cycle: address = counter, data=0, all strobes set; counter increments.
  - CLEAR -> IDLE after writing address 2^ADDR_W-1; a full sweep is exactly 2^ADDR_W busy cycles.
  - The counter wraps to 0 on exit.
- While busy_o=1:
  - w_en_i and r_en_i are ignored: no user writes, no reads launched, r_valid_o=0.
  - clear_i is ignored; it neither restarts nor extends the sweep.
  - Reset mid-sweep restarts the sweep from 0 if CLEAR_ON_RST=1, else the FSM returns to IDLE with memory partially cleared.
- Write (IDLE):
  - Byte b of word w_addr_i takes w_data_i[8b+7:8b] at the edge when w_en_i=1 and w_strb_i[b]=1.
  - w_strb_i=0 means no write.
- Tile decode:
  - Tile index is addr[ADDR_W-1:TILE_ADDR_W]; only the selected tile is enabled.
  - Read tile index is registered alongside the tile output for the output mux.
- Read (IDLE), r_en_i=1 at edge N:
  - OUT_REG=0: data on r_data_o and r_valid_o=1 after edge N+1.
  - OUT_REG=1: data on r_data_o and r_valid_o=1 after edge N+2.
  - Reads are fully pipelined; one read can be issued per cycle.
- r_en_i=0: r_valid_o=0 in the corresponding result slot; r_data_o holds its last value.
- Same-address read and write in the same cycle are read-first: the read returns the old data.
- Reads in flight when a clear starts still complete with their pre-clear data.

Test Plan:
1. Defaults; assert rst_i for 2 cycles, then release. Required: busy_o=1 for exactly 4096 cycles, then 0. Reads of addresses 0, 1023, 1024 and 4095 then return 0 with r_valid_o=1 two cycles after each r_en_i.
2. Write addresses 0..4095 with data i+32 and w_strb_i=4'hF, then read them back sequentially. Required: r_data_o=i+32 at issue+2, back-to-back across the tile boundaries 1023/1024 and 3071/3072. Repeat with OUT_REG=0 and require issue+1.
3. Write 0xAABBCCDD to address 5, then 0x11223344 with w_strb_i=4'b0010, then read address 5. Required: 0xAABB33DD.
4. Address 7 holds 0x20. In one cycle write 0x99 to address 7 and read address 7. Required: the read returns 0x20 and the next read returns 0x99.
5. From IDLE, pulse clear_i, then after 100 cycles pulse clear_i again and assert w_en_i to address 9 with 0x55. Required: busy_o stays high for exactly 4096 cycles from the first pulse, and address 9 reads 0. Repeat with rst_i asserted mid-sweep: the sweep restarts and runs a full 4096 cycles.
6. Read address 3 (value 0x23), then hold r_en_i=0 for 5 cycles. Required: r_valid_o=0 during those cycles and r_data_o stays 0x23.
